// File: rtl/am_sample_feeder.sv
// Sample feeder for the AM modulator. Bursty host writes go into a small FIFO,
// and one sample is released per PWM frame (SAMPLE_PERIOD clocks) with a 1-cycle strobe.
// Write backpressure comes from wr_ready, which is low while full. Output pacing has no backpressure, and mid-scale is emitted on prefill or underflow.
module am_sample_feeder #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int SAMPLE_PERIOD = 1024,
    parameter int PREFILL       = 8,
    parameter int IDLE_VALUE    = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] sample_out,
    output logic                  sample_strobe,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  playing,
    output logic                  underflow,
    input  logic                  underflow_clr,
    output logic [15:0]           underflow_cnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [CW-1:0]         LAST_CNT    = CW'(SAMPLE_PERIOD - 1);
    localparam logic [ADDR_WIDTH:0]   FULL_LVL    = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   PREFILL_LVL = (ADDR_WIDTH + 1)'(PREFILL);
    localparam logic [DATA_WIDTH-1:0] IDLE_DAT    = DATA_WIDTH'(IDLE_VALUE);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_level;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_sample;
    logic                  r_strobe;
    logic                  r_underflow;
    logic [15:0]           r_ucnt;

    logic w_tick;
    logic w_push;
    logic w_pop;
    logic w_uf_evt;

    // All frame decisions use the level as registered before this edge's push.
    assign w_tick   = en && (r_cnt == LAST_CNT);
    assign w_push   = wr_valid && (r_level != FULL_LVL);
    assign w_pop    = w_tick && (((r_state == ST_IDLE) && (r_level >= PREFILL_LVL)) ||
                                 ((r_state == ST_RUN)  && (r_level != '0)));
    assign w_uf_evt = w_tick && (r_state == ST_RUN) && (r_level == '0);

    // Frame counter: free-runs while enabled and sits at zero otherwise.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST_CNT) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // FIFO storage. Stale contents after reset are harmless because the pointers restart.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    // Pointers and occupancy. A simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Playback FSM with registered sample and strobe. One action is taken per tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_sample <= IDLE_DAT;
            r_strobe <= 1'b0;
        end else if (!en) begin
            r_state  <= ST_IDLE;
            r_sample <= IDLE_DAT;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= w_tick;
            if (w_tick) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_pop) begin
                            r_sample <= r_mem[r_rptr];
                            r_state  <= ST_RUN;
                        end else begin
                            r_sample <= IDLE_DAT;
                        end
                    end
                    ST_RUN: begin
                        if (w_pop) begin
                            r_sample <= r_mem[r_rptr];
                        end else begin
                            r_sample <= IDLE_DAT;
                            r_state  <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_sample <= IDLE_DAT;
                        r_state  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Sticky underflow flag and saturating event count. A new event beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_underflow <= 1'b0;
            r_ucnt      <= '0;
        end else if (w_uf_evt) begin
            r_underflow <= 1'b1;
            if (underflow_clr) begin
                r_ucnt <= 16'd1;
            end else if (r_ucnt != 16'hFFFF) begin
                r_ucnt <= r_ucnt + 16'd1;
            end
        end else if (underflow_clr) begin
            r_underflow <= 1'b0;
            r_ucnt      <= '0;
        end
    end

    assign wr_ready      = (r_level != FULL_LVL);
    assign sample_out    = r_sample;
    assign sample_strobe = r_strobe;
    assign level         = r_level;
    assign playing       = (r_state == ST_RUN);
    assign underflow     = r_underflow;
    assign underflow_cnt = r_ucnt;

endmodule
